// File: rtl/regfile_writeback.sv
// regfile_writeback: writeback arbiter (LSU over ALU) with a registered
// register-file write port, an in-flight destination scoreboard and an
// optional bypass of the committing write.
// Optional feature macro: WB_BYPASS_EN (bypass compare); when undefined the
// fwd outputs are tied to zero.
module regfile_writeback #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alu_valid,
   output logic                    alu_ready,
   input  logic [$clog2(NREG)-1:0] alu_rd,
   input  logic [XLEN-1:0]         alu_data,
   input  logic                    lsu_valid,
   output logic                    lsu_ready,
   input  logic [$clog2(NREG)-1:0] lsu_rd,
   input  logic [XLEN-1:0]         lsu_data,
   input  logic                    issue_valid,
   input  logic [$clog2(NREG)-1:0] issue_rd,
   output logic                    wb_en,
   output logic [$clog2(NREG)-1:0] wb_rd,
   output logic [XLEN-1:0]         wb_data,
   output logic [NREG-1:0]         busy,
   input  logic [$clog2(NREG)-1:0] rs1_address,
   input  logic [$clog2(NREG)-1:0] rs2_address,
   output logic                    rs1_fwd_valid,
   output logic                    rs2_fwd_valid,
   output logic [XLEN-1:0]         rs1_fwd_data,
   output logic [XLEN-1:0]         rs2_fwd_data
);

   localparam int unsigned RW = $clog2(NREG);

   logic            lsu_xfer;
   logic            alu_xfer;
   logic            xfer;
   logic [RW-1:0]   win_rd;
   logic [XLEN-1:0] win_data;
   logic [NREG-1:0] busy_next;

   // Fixed-priority arbitration: LSU always wins, ALU waits while LSU is valid
   always_comb begin
      lsu_ready = !rst;
      alu_ready = !rst && !lsu_valid;
      lsu_xfer  = lsu_valid && lsu_ready;
      alu_xfer  = alu_valid && alu_ready;
      xfer      = lsu_xfer || alu_xfer;
      win_rd    = lsu_xfer ? lsu_rd   : alu_rd;
      win_data  = lsu_xfer ? lsu_data : alu_data;
   end

   // Registered write port; rd/data hold when idle, x0 transfers never write
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_en   <= 1'b0;
         wb_rd   <= '0;
         wb_data <= '0;
      end else if (xfer) begin
         wb_en   <= (win_rd != '0);
         wb_rd   <= win_rd;
         wb_data <= win_data;
      end else begin
         wb_en   <= 1'b0;
      end
   end

   // Scoreboard update: clear on retiring transfer, then set on issue so a
   // same-cycle issue of the same rd keeps the bit high
   always_comb begin
      busy_next = busy;
      if (xfer)
         busy_next[win_rd] = 1'b0;
      if (issue_valid && (issue_rd != '0))
         busy_next[issue_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   // Scoreboard register
   always_ff @(posedge clk) begin
      if (rst)
         busy <= '0;
      else
         busy <= busy_next;
   end

`ifdef WB_BYPASS_EN
   // Bypass of the write currently presented to the register file
   always_comb begin
      rs1_fwd_valid = wb_en && (wb_rd == rs1_address) && (rs1_address != '0);
      rs2_fwd_valid = wb_en && (wb_rd == rs2_address) && (rs2_address != '0);
      rs1_fwd_data  = rs1_fwd_valid ? wb_data : '0;
      rs2_fwd_data  = rs2_fwd_valid ? wb_data : '0;
   end
`else
   logic unused_rs;

   // Bypass absent: forward outputs tied off, read addresses unused
   always_comb begin
      unused_rs     = ^{rs1_address, rs2_address};
      rs1_fwd_valid = 1'b0;
      rs2_fwd_valid = 1'b0;
      rs1_fwd_data  = '0;
      rs2_fwd_data  = '0;
   end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed table-driven bench for regfile_writeback,
// plus a hand-written LSU-starvation sequence.
module tb_regfile_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready, lsu_valid, lsu_ready, issue_valid;
   logic [4:0]  alu_rd, lsu_rd, issue_rd, wb_rd, rs1_address, rs2_address;
   logic [31:0] alu_data, lsu_data, wb_data, busy;
   logic        wb_en, rs1_fwd_valid, rs2_fwd_valid;
   logic [31:0] rs1_fwd_data, rs2_fwd_data;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   always #5 clk = ~clk;

   regfile_writeback #(.XLEN(32), .NREG(32)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy),
      .rs1_address(rs1_address), .rs2_address(rs2_address),
      .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
      .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data)
   );

   typedef struct {
      logic        rst;
      logic        av;  logic [4:0] ard; logic [31:0] ad;
      logic        lv;  logic [4:0] lrd; logic [31:0] ld;
      logic        iv;  logic [4:0] ird;
      logic [4:0]  rs1; logic [4:0] rs2;
      logic        ear; logic       elr;
      logic        een; logic [4:0] erd; logic [31:0] edata; logic [31:0] ebusy;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input int unsigned idx,
                        input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst;
      alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
      lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
      issue_valid = v.iv; issue_rd = v.ird;
      rs1_address = v.rs1; rs2_address = v.rs2;
   endtask

   initial begin
      logic        f1v, f2v;
      logic [31:0] f1d, f2d;

      rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
      alu_rd = '0; lsu_rd = '0; issue_rd = '0; alu_data = '0; lsu_data = '0;
      rs1_address = '0; rs2_address = '0;

      //            rst  av   ard    ad             lv   lrd    ld             iv   ird    rs1    rs2    ear  elr  een  erd    edata          ebusy
      vecs[0]  = '{1'b1,1'b1,5'd5, 32'h12345678,1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 32'h0,        32'h0};
      vecs[1]  = '{1'b0,1'b1,5'd5, 32'h12345678,1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b1,1'b1,5'd5, 32'h12345678, 32'h0};
      vecs[2]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b1,1'b0,5'd5, 32'h12345678, 32'h0};
      vecs[3]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,        1'b1,5'd7, 5'd0, 5'd0, 1'b1,1'b1,1'b0,5'd5, 32'h12345678, 32'h80};
      vecs[4]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,        1'b1,5'd3, 5'd0, 5'd0, 1'b1,1'b1,1'b0,5'd5, 32'h12345678, 32'h88};
      vecs[5]  = '{1'b0,1'b1,5'd3, 32'hA,       1'b1,5'd4, 32'hB,        1'b1,5'd4, 5'd0, 5'd0, 1'b0,1'b1,1'b1,5'd4, 32'hB,        32'h98};
      vecs[6]  = '{1'b0,1'b1,5'd3, 32'hA,       1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b1,1'b1,5'd3, 32'hA,        32'h90};
      vecs[7]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd7, 32'h77,       1'b1,5'd7, 5'd0, 5'd0, 1'b0,1'b1,1'b1,5'd7, 32'h77,       32'h90};
      vecs[8]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd7, 32'h78,       1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b1,5'd7, 32'h78,       32'h10};
      vecs[9]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd0, 32'hFFFFFFFF, 1'b1,5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b0,5'd0, 32'hFFFFFFFF, 32'h10};
      vecs[10] = '{1'b0,1'b1,5'd9, 32'h55,      1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd9, 5'd0, 1'b1,1'b1,1'b1,5'd9, 32'h55,       32'h10};
      vecs[11] = '{1'b0,1'b1,5'd4, 32'h44,      1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd9, 5'd4, 1'b1,1'b1,1'b1,5'd4, 32'h44,       32'h0};
      vecs[12] = '{1'b0,1'b1,5'd6, 32'h66,      1'b0,5'd0, 32'h0,        1'b1,5'd2, 5'd0, 5'd0, 1'b1,1'b1,1'b1,5'd6, 32'h66,       32'h4};
      vecs[13] = '{1'b1,1'b1,5'd8, 32'h88,      1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 32'h0,        32'h0};
      vecs[14] = '{1'b0,1'b1,5'd8, 32'h88,      1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b1,1'b1,5'd8, 32'h88,       32'h0};
      vecs[15] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b1,1'b0,5'd8, 32'h88,       32'h0};

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check("alu_ready", i, {31'b0, alu_ready}, {31'b0, vecs[i].ear});
         check("lsu_ready", i, {31'b0, lsu_ready}, {31'b0, vecs[i].elr});
         @(posedge clk);
         #1;
         check("wb_en",   i, {31'b0, wb_en}, {31'b0, vecs[i].een});
         check("wb_rd",   i, {27'b0, wb_rd}, {27'b0, vecs[i].erd});
         check("wb_data", i, wb_data, vecs[i].edata);
         check("busy",    i, busy, vecs[i].ebusy);
`ifdef WB_BYPASS_EN
         f1v = vecs[i].een && (vecs[i].erd == vecs[i].rs1) && (vecs[i].rs1 != 5'd0);
         f2v = vecs[i].een && (vecs[i].erd == vecs[i].rs2) && (vecs[i].rs2 != 5'd0);
`else
         f1v = 1'b0;
         f2v = 1'b0;
`endif
         f1d = f1v ? vecs[i].edata : 32'h0;
         f2d = f2v ? vecs[i].edata : 32'h0;
         check("rs1_fwd_valid", i, {31'b0, rs1_fwd_valid}, {31'b0, f1v});
         check("rs2_fwd_valid", i, {31'b0, rs2_fwd_valid}, {31'b0, f2v});
         check("rs1_fwd_data",  i, rs1_fwd_data, f1d);
         check("rs2_fwd_data",  i, rs2_fwd_data, f2d);
      end

      // ALU result starved by three back-to-back LSU results, then drains
      @(negedge clk);
      issue_valid = 1'b0; rs1_address = '0; rs2_address = '0;
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAAAA;
      for (int k = 0; k < 3; k++) begin
         lsu_valid = 1'b1; lsu_rd = 5'(11 + k); lsu_data = 32'hB0 + 32'(k);
         #1;
         check("starve_alu_ready", 100 + k, {31'b0, alu_ready}, 32'h0);
         @(posedge clk);
         #1;
         check("starve_wb_en", 100 + k, {31'b0, wb_en}, 32'h1);
         check("starve_wb_rd", 100 + k, {27'b0, wb_rd}, 32'(11 + k));
         check("starve_wb_data", 100 + k, wb_data, 32'hB0 + 32'(k));
         @(negedge clk);
      end
      lsu_valid = 1'b0;
      #1;
      check("drain_alu_ready", 103, {31'b0, alu_ready}, 32'h1);
      @(posedge clk);
      #1;
      check("drain_wb_en",   103, {31'b0, wb_en}, 32'h1);
      check("drain_wb_rd",   103, {27'b0, wb_rd}, 32'd10);
      check("drain_wb_data", 103, wb_data, 32'hAAAA);
      @(negedge clk);
      alu_valid = 1'b0;
      @(posedge clk);
      #1;
      check("drain_idle_wb_en", 104, {31'b0, wb_en}, 32'h0);
      check("drain_idle_busy",  104, busy, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
